// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder/subtractor.
// FSM state encoding used by serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational.
// Ripple element for the serial_adder slice chain.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract, DIGIT bits per cycle LSB first; latency WIDTH/DIGIT cycles from accept.
// One operation in flight; result held in DONE until ready_i, operands refused outside IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, c_q;

  logic [DIGIT-1:0] a_sl, b_sl, s_sl;
  logic [DIGIT:0]   cy;

  assign a_sl  = a_q[cnt_q * DIGIT +: DIGIT];
  assign b_sl  = b_q[cnt_q * DIGIT +: DIGIT];
  assign cy[0] = carry_q;

  for (genvar g = 0; g < DIGIT; g++) begin : g_chain
    full_adder u_fa (
      .a_i (a_sl[g]),
      .b_i (b_sl[g]),
      .c_i (cy[g]),
      .s_o (s_sl[g]),
      .c_o (cy[g+1])
    );
  end

  always_comb begin
    sum_d = sum_q;
    sum_d[cnt_q * DIGIT +: DIGIT] = s_sl;
  end

  // Subtraction is A + ~B + 1, so the carry seed replaces c_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : c_i;
            cnt_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= cy[DIGIT];
          if (cnt_q == CW'(N - 1)) begin
            s_q     <= sum_d;
            c_q     <= cy[DIGIT];
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign s_o     = s_q;
  assign c_o     = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: five instances (W8 D1/D4/D8, W2 D1/D2) against an arithmetic model.
module tb_serial_adder;

  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] a8, b8;
  logic       c8, sub8, vld8, rdy8;
  logic [1:0] a2, b2;
  logic       c2, sub2, vld2, rdy2;

  logic       vo [5];
  logic       ro [5];
  logic       co [5];
  logic [7:0] s8 [3];
  logic [1:0] s2 [2];

  localparam int NCYC [5] = '{8, 2, 1, 2, 1};
  localparam int WID  [5] = '{8, 8, 8, 2, 2};

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vld8), .ready_o(ro[0]),
    .a_i(a8), .b_i(b8), .c_i(c8), .sub_i(sub8), .valid_o(vo[0]), .ready_i(rdy8), .s_o(s8[0]), .c_o(co[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vld8), .ready_o(ro[1]),
    .a_i(a8), .b_i(b8), .c_i(c8), .sub_i(sub8), .valid_o(vo[1]), .ready_i(rdy8), .s_o(s8[1]), .c_o(co[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vld8), .ready_o(ro[2]),
    .a_i(a8), .b_i(b8), .c_i(c8), .sub_i(sub8), .valid_o(vo[2]), .ready_i(rdy8), .s_o(s8[2]), .c_o(co[2]));
  serial_adder #(.WIDTH(2), .DIGIT(1)) u_w2d1 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vld2), .ready_o(ro[3]),
    .a_i(a2), .b_i(b2), .c_i(c2), .sub_i(sub2), .valid_o(vo[3]), .ready_i(rdy2), .s_o(s2[0]), .c_o(co[3]));
  serial_adder #(.WIDTH(2), .DIGIT(2)) u_w2d2 (.clk_i(clk), .rst_ni(rst_n), .valid_i(vld2), .ready_o(ro[4]),
    .a_i(a2), .b_i(b2), .c_i(c2), .sub_i(sub2), .valid_o(vo[4]), .ready_i(rdy2), .s_o(s2[1]), .c_o(co[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // {carry, sum} from plain integer arithmetic; subtraction carry means "no borrow".
  function automatic logic [8:0] ref_sum(input int w, input int a, input int b, input int c, input int sub);
    int r, mask;
    logic [8:0] res;
    mask = (1 << w) - 1;
    if (sub != 0) begin
      r   = a - b;
      res = {(a >= b), 8'(r & mask)};
    end else begin
      r   = a + b + c;
      res = {(r > mask), 8'(r & mask)};
    end
    return res;
  endfunction

  function automatic logic [8:0] dut_out(input int i);
    if (i < 3) return {co[i], s8[i]};
    else       return {co[i], 6'b0, s2[i-3]};
  endfunction

  // Model: 0 idle, 1 busy for N edges, 2 result presented.
  int         m_state [5];
  int         m_cnt   [5];
  logic [8:0] m_res   [5];
  logic [8:0] m_out   [5];

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      logic iv, ir;
      int   ia, ib, ic, isub;
      iv = (i < 3) ? vld8 : vld2;
      ir = (i < 3) ? rdy8 : rdy2;
      ia = (i < 3) ? int'(a8) : int'(a2);
      ib = (i < 3) ? int'(b8) : int'(b2);
      ic = (i < 3) ? int'(c8) : int'(c2);
      isub = (i < 3) ? int'(sub8) : int'(sub2);
      if (!rst_n) begin
        m_state[i] = 0;
        m_cnt[i]   = 0;
        m_res[i]   = '0;
        m_out[i]   = '0;
      end else if (m_state[i] == 0) begin
        if (iv) begin
          m_state[i] = 1;
          m_cnt[i]   = NCYC[i];
          m_res[i]   = ref_sum(WID[i], ia, ib, ic, isub);
        end
      end else if (m_state[i] == 1) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_state[i] = 2;
          m_out[i]   = m_res[i];
        end
      end else if (ir) begin
        m_state[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("cyc valid_o[%0d]", i), 32'(vo[i]), 32'(m_state[i] == 2));
      chk($sformatf("cyc ready_o[%0d]", i), 32'(ro[i]), 32'(m_state[i] == 0));
      chk($sformatf("cyc {c_o,s_o}[%0d]", i), 32'(dut_out(i)), 32'(m_out[i]));
    end
  end

  // Issue one operation to the three 8-bit instances and pin latency and result by hand.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub,
                     input logic [8:0] exp, input string nm);
    int lat [3];
    lat = '{0, 0, 0};
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; sub8 = sub; vld8 = 1'b1;
    @(negedge clk);
    vld8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sub8 = 1'($urandom);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        if (lat[j] == 0 && vo[j]) begin
          lat[j] = k;
          chk($sformatf("%s result[%0d]", nm, j), 32'(dut_out(j)), 32'(exp));
        end
      end
    end
    chk({nm, " latency D1"}, lat[0], 8);
    chk({nm, " latency D4"}, lat[1], 2);
    chk({nm, " latency D8"}, lat[2], 1);
  endtask

  task automatic op2(input int a, input int b, input int c, input int sub);
    @(negedge clk);
    a2 = 2'(a); b2 = 2'(b); c2 = 1'(c); sub2 = 1'(sub); vld2 = 1'b1;
    @(negedge clk);
    vld2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0; vld8 = 1'b0; rdy8 = 1'b1;
    a2 = '0; b2 = '0; c2 = 1'b0; sub2 = 1'b0; vld2 = 1'b0; rdy2 = 1'b1;

    chk("model 0xFF+0x01", 32'(ref_sum(8, 255, 1, 0, 0)), 32'h100);
    chk("model 0x00-0x01", 32'(ref_sum(8, 0, 1, 0, 1)), 32'h0FF);
    chk("model 3+3+1 w2", 32'(ref_sum(2, 3, 3, 1, 0)), 32'h103);

    repeat (2) @(negedge clk);
    #1;
    chk("reset valid_o", 32'(vo[0]), 0);
    chk("reset ready_o", 32'(ro[0]), 1);
    chk("reset s_o", 32'(s8[0]), 0);
    rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, "add 5A+3C");

    // Reset three cycles into an operation discards it.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0; sub8 = 1'b0; vld8 = 1'b1;
    @(negedge clk);
    vld8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst valid_o", 32'(vo[0]), 0);
    chk("midrst ready_o", 32'(ro[0]), 1);
    chk("midrst s_o", 32'(s8[0]), 0);
    chk("midrst c_o", 32'(co[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h01, 8'h01, 1'b0, 1'b0, 9'h002, "post-reset 01+01");

    op8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "wrap FF+01");
    op8(8'hFF, 8'h00, 1'b1, 1'b0, 9'h100, "wrap FF+00+1");
    op8(8'h7F, 8'h00, 1'b1, 1'b0, 9'h080, "7F+00+1");
    op8(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, "sub 10-01");
    op8(8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF, "sub 00-01");
    op8(8'h10, 8'h01, 1'b1, 1'b1, 9'h10F, "sub 10-01 ci");

    // Backpressure: result must hold while the consumer stalls.
    rdy8 = 1'b0;
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h43; c8 = 1'b1; sub8 = 1'b0; vld8 = 1'b1;
    @(negedge clk);
    vld8 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = vo[0];
    end
    chk("bp done reached", 32'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vld8 = ~vld8; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(posedge clk);
      #1;
      chk("bp valid_o", 32'(vo[0]), 1);
      chk("bp ready_o", 32'(ro[0]), 0);
      chk("bp result", 32'({co[0], s8[0]}), 32'h065);
    end
    @(negedge clk);
    vld8 = 1'b0; rdy8 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release valid_o", 32'(vo[0]), 0);
    chk("bp release ready_o", 32'(ro[0]), 1);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          for (int c = 0; c < 2 - s; c++)
            op2(a, b, c, s);

    op2(3, 3, 1, 0);
    chk("w2d1 3+3+1", 32'({co[3], s2[0]}), 32'h7);
    chk("w2d2 3+3+1", 32'({co[4], s2[1]}), 32'h7);
    op2(0, 1, 1, 1);
    chk("w2d1 0-1", 32'({co[3], s2[0]}), 32'h3);
    chk("w2d2 0-1", 32'({co[4], s2[1]}), 32'h3);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
